// File: rtl/tcd_pkg.sv
// Shared types and default timing for the linear-CCD driver.
// The package holds the FSM states, the sample width and the counter widths.
package tcd_pkg;
  typedef enum logic [2:0] {IDLE, ICG_PRE, SH_HI, ICG_POST, READOUT, DONE} tcd_state_e;

  localparam int SAMPLE_W = 12;
  localparam int PIX_W    = 12;
  localparam int CNT_W    = 16;

  localparam int DEF_FM_DIV   = 4;
  localparam int DEF_N_PIX    = 1100;
  localparam int DEF_T_ICG_SH = 20;
  localparam int DEF_SH_W     = 40;
  localparam int DEF_T_SH_ICG = 40;
endpackage

// File: rtl/adc_capture.sv
// Per-pixel-slot ADC handshake: issues convst, captures the first idle-busy
// sample inside the capture window, stretches valid to 2 cycles, flags overruns.
module adc_capture import tcd_pkg::*; #(
  parameter int PIX_CLK = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic [CNT_W-1:0]    slot_cnt,
  input  logic                slot_start,
  input  logic                adc_busy,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                adc_convst,
  output logic                adc_valid,
  output logic [SAMPLE_W-1:0] adc_value,
  output logic                overrun
);
  logic                in_win, take;
  logic                got_q, got_d;
  logic                ovr_q, ovr_d;
  logic                convst_q;
  logic [1:0]          vld_q, vld_d;
  logic [SAMPLE_W-1:0] value_q, value_d;

  // Last capture at PIX_CLK-3 leaves room for the 2-cycle valid inside the slot.
  always_comb begin
    in_win  = active && (slot_cnt >= CNT_W'(2)) && (slot_cnt <= CNT_W'(PIX_CLK - 3));
    take    = in_win && !got_q && !adc_busy;
    got_d   = (active && (slot_cnt != '0)) ? (got_q | take) : 1'b0;
    vld_d   = {vld_q[0], take};
    value_d = take ? adc_data : value_q;
    ovr_d   = ovr_q | (active && (slot_cnt == CNT_W'(PIX_CLK - 3)) && !got_q && !take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_q    <= 1'b0;
      ovr_q    <= 1'b0;
      convst_q <= 1'b0;
      vld_q    <= '0;
      value_q  <= '0;
    end else begin
      got_q    <= got_d;
      ovr_q    <= ovr_d;
      convst_q <= slot_start;
      vld_q    <= vld_d;
      value_q  <= value_d;
    end
  end

  assign adc_convst = convst_q;
  assign adc_valid  = |vld_q;
  assign adc_value  = value_q;
  assign overrun    = ovr_q;
endmodule

// File: rtl/tcd_drv.sv
// Linear CCD timing driver: free-running master clock, ICG/SH frame sequencing
// and per-pixel ADC readout slots.
module tcd_drv import tcd_pkg::*; #(
  parameter int FM_DIV   = DEF_FM_DIV,
  parameter int N_PIX    = DEF_N_PIX,
  parameter int T_ICG_SH = DEF_T_ICG_SH,
  parameter int SH_W     = DEF_SH_W,
  parameter int T_SH_ICG = DEF_T_SH_ICG,
  parameter int PIX_CLK  = 8 * FM_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                tcd_fm,
  output logic                tcd_icg,
  output logic                tcd_sh,
  output logic                adc_convst,
  input  logic                adc_busy,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                adc_valid,
  output logic [SAMPLE_W-1:0] adc_value,
  output logic                frame_done,
  output logic                overrun
);
  tcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] fm_cnt_q, fm_cnt_d;
  logic             fm_q, fm_d;
  logic             icg_q, icg_d, sh_q, sh_d, done_q, done_d;
  logic             slot_start;

  always_comb begin
    fm_cnt_d = fm_cnt_q + CNT_W'(1);
    fm_d     = fm_q;
    if (fm_cnt_q == CNT_W'(FM_DIV - 1)) begin
      fm_cnt_d = '0;
      fm_d     = ~fm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = ICG_PRE;
      end
      ICG_PRE: if (cnt_q == CNT_W'(T_ICG_SH - 1)) begin
        state_d = SH_HI;
        cnt_d   = '0;
      end
      SH_HI: if (cnt_q == CNT_W'(SH_W - 1)) begin
        state_d = ICG_POST;
        cnt_d   = '0;
      end
      ICG_POST: if (cnt_q == CNT_W'(T_SH_ICG - 1)) begin
        state_d = READOUT;
        cnt_d   = '0;
        pix_d   = '0;
      end
      READOUT: if (cnt_q == CNT_W'(PIX_CLK - 1)) begin
        cnt_d = '0;
        if (pix_q == PIX_W'(N_PIX - 1)) state_d = DONE;
        else                            pix_d   = pix_q + PIX_W'(1);
      end
      DONE: begin
        cnt_d   = '0;
        state_d = start ? ICG_PRE : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they change with the state.
    icg_d      = !(state_d inside {ICG_PRE, SH_HI, ICG_POST});
    sh_d       = (state_d == SH_HI);
    done_d     = (state_d == DONE);
    slot_start = (state_d == READOUT) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pix_q    <= '0;
      fm_cnt_q <= '0;
      fm_q     <= 1'b0;
      icg_q    <= 1'b1;
      sh_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
      fm_cnt_q <= fm_cnt_d;
      fm_q     <= fm_d;
      icg_q    <= icg_d;
      sh_q     <= sh_d;
      done_q   <= done_d;
    end
  end

  adc_capture #(.PIX_CLK(PIX_CLK)) u_cap (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == READOUT),
    .slot_cnt   (cnt_q),
    .slot_start (slot_start),
    .adc_busy   (adc_busy),
    .adc_data   (adc_data),
    .adc_convst (adc_convst),
    .adc_valid  (adc_valid),
    .adc_value  (adc_value),
    .overrun    (overrun)
  );

  assign tcd_fm     = fm_q;
  assign tcd_icg    = icg_q;
  assign tcd_sh     = sh_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_tcd_drv.sv
// Directed bench for tcd_drv with an ADC model feeding a scoreboard of
// expected samples; a negedge monitor checks waveform timing continuously.
module tb_tcd_drv;
  localparam int T_ICG_SH = 3;
  localparam int SH_W     = 5;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, adc_busy = 1'b0;
  logic [11:0] adc_data = '0;
  logic        tcd_fm, tcd_icg, tcd_sh, adc_convst, adc_valid, frame_done, overrun;
  logic [11:0] adc_value;

  int          n_assert = 0, n_fail = 0;
  logic [11:0] exp_q[$];
  logic [11:0] base = 12'h5A0, cur_val = '0;
  int          pix_idx = 0, stuck_pix = -1, busy_cnt = 0;
  bit          busy_stuck = 0;
  int          vp_cnt = 0, done_cnt = 0, sh_rise_cnt = 0;
  int          vw = 0, sh_w = 0, icg_lo = 0, fm_per = 0;
  bit          fm_seen = 0;
  logic        valid_prev = 0, sh_prev = 0, fm_prev = 0;

  tcd_drv #(.FM_DIV(2), .N_PIX(4), .T_ICG_SH(T_ICG_SH), .SH_W(SH_W), .T_SH_ICG(4), .PIX_CLK(16)) dut (
    .clk(clk), .rst(rst), .start(start), .tcd_fm(tcd_fm), .tcd_icg(tcd_icg), .tcd_sh(tcd_sh),
    .adc_convst(adc_convst), .adc_busy(adc_busy), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_value(adc_value), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 400 && done_cnt < target; k++) @(negedge clk);
    chk("frame_done_reached", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_sh(input int target);
    for (int k = 0; k < 400 && sh_rise_cnt < target; k++) @(negedge clk);
    chk("sh_rise_reached", 32'(sh_rise_cnt >= target), 1);
  endtask

  // Monitor and ADC model; DUT outputs only move on posedge, so negedge is race-free.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; busy_stuck = 0; adc_busy = 1'b0; pix_idx = 0;
      vw = 0; sh_w = 0; icg_lo = 0; fm_per = 0; fm_seen = 0;
      valid_prev = 0; sh_prev = 0; fm_prev = 0;
      exp_q.delete();
    end else begin
      fm_per++;
      if (tcd_fm && !fm_prev) begin
        if (fm_seen) chk("fm_period", fm_per, 4);
        fm_seen = 1; fm_per = 0;
      end
      fm_prev = tcd_fm;

      if (!tcd_icg && !tcd_sh) icg_lo++;
      else if (tcd_icg)        icg_lo = 0;
      if (tcd_sh) sh_w++;
      if (tcd_sh && !sh_prev) begin
        sh_rise_cnt++;
        chk("icg_to_sh", icg_lo, T_ICG_SH);
        pix_idx = 0;
      end
      if (!tcd_sh && sh_prev) begin
        chk("sh_width", sh_w, SH_W);
        sh_w = 0;
      end
      sh_prev = tcd_sh;

      if (adc_valid) begin
        vw++;
        chk("valid_while_sh", 32'(tcd_sh), 0);
      end
      if (adc_valid && !valid_prev) begin
        vp_cnt++;
        chk("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("adc_value", 32'(adc_value), 32'(exp_q.pop_front()));
      end
      if (!adc_valid && valid_prev) begin
        chk("valid_width", vw, 2);
        vw = 0;
      end
      valid_prev = adc_valid;
      if (frame_done) done_cnt++;

      if (busy_cnt > 0) busy_cnt--;
      if (adc_convst) begin
        cur_val = base + pix_idx[11:0];
        if (pix_idx == stuck_pix) busy_stuck = 1;
        else begin
          busy_stuck = 0;
          busy_cnt   = 4;
          exp_q.push_back(cur_val);
        end
        pix_idx++;
      end
      adc_busy = busy_stuck || (busy_cnt > 0);
      adc_data = adc_busy ? 12'hFFF : cur_val;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0, s0;
    bit icg_hi;
    repeat (3) @(negedge clk);
    chk("rst_fm", 32'(tcd_fm), 0);
    chk("rst_icg", 32'(tcd_icg), 1);
    chk("rst_sh", 32'(tcd_sh), 0);
    chk("rst_convst", 32'(adc_convst), 0);
    chk("rst_valid", 32'(adc_valid), 0);
    chk("rst_value", 32'(adc_value), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_icg", 32'(tcd_icg), 1);
    chk("idle_sh", 32'(tcd_sh), 0);

    // Single frame, nominal ADC
    v0 = vp_cnt; d0 = done_cnt; s0 = sh_rise_cnt;
    start = 1'b1;
    for (int k = 0; k < 20 && tcd_icg; k++) @(negedge clk);
    chk("t1_icg_fell", 32'(tcd_icg), 0);
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);
    chk("t1_valids", vp_cnt - v0, 4);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_frames", sh_rise_cnt - s0, 1);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_ovr", 32'(overrun), 0);
    chk("t1_icg_idle", 32'(tcd_icg), 1);

    // Busy stuck on pixel 2
    v0 = vp_cnt; d0 = done_cnt; s0 = sh_rise_cnt;
    stuck_pix = 2;
    start = 1'b1;
    wait_sh(s0 + 1);
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);
    chk("t2_valids", vp_cnt - v0, 3);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_ovr", 32'(overrun), 1);
    repeat (20) @(negedge clk);
    chk("t2_ovr_sticky", 32'(overrun), 1);
    stuck_pix = -1;
    rst = 1'b1;
    #1 chk("rst_ovr_clear", 32'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // start dropped during pixel 1
    v0 = vp_cnt; d0 = done_cnt; s0 = sh_rise_cnt;
    start = 1'b1;
    wait_sh(s0 + 1);
    for (int k = 0; k < 200 && pix_idx < 2; k++) @(negedge clk);
    chk("t3_pix1_reached", 32'(pix_idx >= 2), 1);
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);
    chk("t3_valids", vp_cnt - v0, 4);
    chk("t3_done", done_cnt - d0, 1);
    s0 = sh_rise_cnt;
    icg_hi = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!tcd_icg) icg_hi = 0;
    end
    chk("t3_icg_stays_high", 32'(icg_hi), 1);
    chk("t3_no_restart", sh_rise_cnt - s0, 0);

    // Reset during SH_HI, then a clean frame
    s0 = sh_rise_cnt;
    start = 1'b1;
    wait_sh(s0 + 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_sh_rst", 32'(tcd_sh), 0);
    chk("t4_icg_rst", 32'(tcd_icg), 1);
    chk("t4_fm_rst", 32'(tcd_fm), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    v0 = vp_cnt; d0 = done_cnt; s0 = sh_rise_cnt;
    wait_sh(s0 + 1);
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);
    chk("t4_valids", vp_cnt - v0, 4);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_ovr", 32'(overrun), 0);

    // Three back-to-back frames
    base = 12'h3C0;
    v0 = vp_cnt; d0 = done_cnt; s0 = sh_rise_cnt;
    start = 1'b1;
    wait_done(d0 + 2);
    wait_sh(s0 + 3);
    start = 1'b0;
    wait_done(d0 + 3);
    repeat (5) @(negedge clk);
    chk("t5_valids", vp_cnt - v0, 12);
    chk("t5_done", done_cnt - d0, 3);
    chk("t5_frames", sh_rise_cnt - s0, 3);
    chk("t5_sb_empty", exp_q.size(), 0);
    chk("t5_ovr", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
